ball_packet_i2c_target: RTL
===========================

// Module: ball_packet_i2c_target
// PURPOSE
// - I2C target that receives the 6-byte ball packet sent by the peer board's I2C master.
// - Decodes the packet into ball state for the local game engine; one-cycle rx_valid per good frame.
// - Drives ACK/NACK on the open-drain SDA line.
// - Sits beside the I2C master path inside the player-link interface.
// PARAMETERS
// - TARGET_ADDR  7'h42  7-bit I2C address this block answers to.
// - NUM_BYTES    6      data bytes in one write frame.
// - SYNC_STAGES  2      flip-flop stages on SCL/SDA inputs (>=2).
// PORTS
// - clk            in     1   system clock; >=8x SCL rate.
// - reset          in     1   asynchronous, active-low reset.
// - SCL            in     1   I2C clock from the remote master.
// - SDA            inout  1   open-drain: drive 1'b0 or 1'bz only.
// - rx_valid       out    1   one-cycle pulse; decoded outputs updated this cycle.
// - ball_y         out    10  {byte0[1:0], byte1}.
// - ball_vy        out    8   byte2.
// - gravity_counter out   2   byte3[1:0].
// - is_collision   out    1   byte4[0].
// - is_win_flag    out    1   byte5[0].
// - busy           out    1   high from address match until STOP or START.
// - frame_err      out    1   one-cycle pulse on a bad frame.
// BEHAVIOUR
// - Reset: all outputs 0, SDA released (z), FSM=IDLE, staging bytes=0.
// - Input sync
//   - SCL and SDA pass through SYNC_STAGES flops.
//   - Edge detect uses the synced value and a one-cycle-delayed copy.
// - Bus conditions
//   - START: SDA fall while SCL high.
//   - STOP: SDA rise while SCL high.
//   - Both are checked every cycle, in every state, with priority over bit handling.
// - Bit timing
//   - Sample SDA on a synced SCL rise.
//   - Change the SDA drive only on a synced SCL fall.
//   - Bits are MSB first.
// - FSM: IDLE -> ADDR -> ADDR_ACK -> DATA <-> DATA_ACK; IGNORE.
//   - IDLE: wait for START.
//   - ADDR: shift in 8 bits.
//     - Match means addr==TARGET_ADDR and R/W=0.
//     - On match: drive ACK (SDA=0) from the 8th-bit SCL fall to the 9th-bit SCL fall, then go to DATA.
//     - On mismatch: go to IGNORE and never drive SDA.
//   - DATA: shift in 8 bits, then store into staging[byte_cnt].
//     - byte_cnt < NUM_BYTES: ACK and increment byte_cnt.
//     - byte_cnt == NUM_BYTES (overflow): NACK, set ovf flag, go to IGNORE.
//   - IGNORE: SDA released; leave only on START or STOP.
// - STOP handling
//   - Good frame = matched, byte_cnt == NUM_BYTES, no ovf.
//     - Copy all fields from staging atomically.
//     - Pulse rx_valid in the cycle after STOP detect.
//   - Matched frame that is not good: pulse frame_err; outputs keep their old values.
//   - Then go to IDLE.
// - Repeated START (any state): discard staging, clear byte_cnt/ovf, go to ADDR, no pulses.
// - Latency: pin SDA rise for STOP -> rx_valid within SYNC_STAGES+2 clk.
// - Outputs are never partially updated.
// - rx_valid and frame_err are mutually exclusive.
// - Reset mid-frame: SDA released immediately (async), FSM=IDLE, partial frame lost.
// CONFIGURATION
// - BALL_RX_READBACK_EN defined
//   - R/W=1 with a matching address is ACKed; FSM adds READ/READ_ACK states.
//   - Target shifts out the last good packet bytes 0..5, MSB first.
//   - Master NACK -> IGNORE. Reads past byte 5 return 8'h00.
//   - busy is high during the read; no rx_valid or frame_err for reads.
// - BALL_RX_READBACK_EN undefined
//   - R/W=1 is treated as an address mismatch: no ACK, IGNORE.
// TESTING
// - Write 0x84, 02 5A F3 01 01 00, STOP
//   - 7 ACKs.
//   - rx_valid 1 clk: ball_y=10'h25A, ball_vy=8'hF3, gravity_counter=1, is_collision=1, is_win_flag=0.
// - Address 0x86 (addr 0x43), 6 bytes, STOP
//   - SDA never driven low, busy=0, no rx_valid or frame_err.
// - Write 0x84 + 4 bytes, STOP
//   - frame_err pulse; outputs keep previous values.
// - Write 0x84 + 7 bytes
//   - 7th byte NACKed; frame_err on STOP; outputs unchanged.
// - Write 0x84 + 3 bytes, repeated START, 0x84 + 01 10 05 02 00 01, STOP
//   - Single rx_valid: ball_y=10'h110, ball_vy=8'h05, gravity_counter=2, is_collision=0, is_win_flag=1.
// - reset low after byte 3 of a frame
//   - SDA=z, all outputs 0.
//   - Next full frame decodes normally.
//   - With BALL_RX_READBACK_EN: read 0x85 returns the last good packet.

Source files
------------

// File: rtl/ball_packet_i2c_target.sv
// ball_packet_i2c_target: I2C write target decoding the 6-byte ball packet; define BALL_RX_READBACK_EN to add read-back of the last good packet
module ball_packet_i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int NUM_BYTES = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       rx_valid,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic       is_collision,
  output logic       is_win_flag,
  output logic       busy,
  output logic       frame_err
);
  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] NB = CW'(NUM_BYTES);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
`ifdef BALL_RX_READBACK_EN
    , READ, READ_ACK
`endif
  } state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_d, sda_d, scl_s, sda_s;
  logic start, stop, rise, fall, bit8, hit, sample, fin, good;
  logic [7:0] sh;
  logic [3:0] bit_cnt;
  logic [CW-1:0] byte_cnt;
  logic ovf, rd, drive;
  logic [7:0] staging [NUM_BYTES];
  assign SDA = drive ? 1'b0 : 1'bz;
  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_s = sda_q[SYNC_STAGES-1];
  assign start = scl_s && scl_d && sda_d && !sda_s;
  assign stop = scl_s && scl_d && !sda_d && sda_s;
  assign rise = scl_s && !scl_d;
  assign fall = !scl_s && scl_d;
  assign bit8 = bit_cnt == 4'd8;
  assign fin = stop && busy && !rd;
  assign good = byte_cnt == NB && !ovf;
`ifdef BALL_RX_READBACK_EN
  logic [7:0] pkt [NUM_BYTES];
  logic [7:0] tx;
  assign tx = byte_cnt < NB ? pkt[byte_cnt] : 8'h00;
  assign hit = sh[7:1] == TARGET_ADDR;
  assign sample = rise && state != READ;
`else
  assign hit = sh[7:1] == TARGET_ADDR && !sh[0];
  assign sample = rise;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], SCL};
      sda_q <= {sda_q[SYNC_STAGES-2:0], SDA};
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end
  always_ff @(posedge clk or negedge reset)
    state <= !reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (start) state_n = ADDR;
    else if (stop) state_n = IDLE;
    else
      case (state)
        ADDR: if (fall && bit8) state_n = hit ? ADDR_ACK : IGNORE;
        DATA: if (fall && bit8) state_n = byte_cnt == NB ? IGNORE : DATA_ACK;
        DATA_ACK: if (fall) state_n = DATA;
`ifdef BALL_RX_READBACK_EN
        ADDR_ACK: if (fall) state_n = rd ? READ : DATA;
        READ: if (fall && bit8) state_n = READ_ACK;
        READ_ACK: state_n = rise && sda_s ? IGNORE : fall ? READ : READ_ACK;
`else
        ADDR_ACK: if (fall) state_n = DATA;
`endif
        default: state_n = state;
      endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      {ovf, rd, drive, busy, rx_valid, frame_err} <= '0;
      {ball_y, ball_vy, gravity_counter, is_collision, is_win_flag} <= '0;
      for (int i = 0; i < NUM_BYTES; i++) staging[i] <= '0;
`ifdef BALL_RX_READBACK_EN
      for (int i = 0; i < NUM_BYTES; i++) pkt[i] <= '0;
`endif
    end else begin
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      if (start || stop) begin
        bit_cnt <= '0;
        byte_cnt <= '0;
        {ovf, rd, drive, busy} <= '0;
        rx_valid <= fin && good;
        frame_err <= fin && !good;
        if (fin && good) begin
          ball_y <= {staging[0][1:0], staging[1]};
          ball_vy <= staging[2];
          gravity_counter <= staging[3][1:0];
          is_collision <= staging[4][0];
          is_win_flag <= staging[5][0];
`ifdef BALL_RX_READBACK_EN
          pkt <= staging;
`endif
        end
      end else begin
        if (rise) bit_cnt <= bit_cnt + 4'd1;
        if (sample) sh <= {sh[6:0], sda_s};
        if (fall)
          case (state)
            ADDR: if (bit8 && hit) begin
              drive <= 1'b1;
              busy <= 1'b1;
              rd <= sh[0];
            end
            ADDR_ACK, DATA_ACK: begin
              bit_cnt <= '0;
              drive <= 1'b0;
            end
            DATA: if (bit8) begin
              if (byte_cnt == NB) ovf <= 1'b1;
              else begin
                staging[byte_cnt] <= sh;
                byte_cnt <= byte_cnt + CW'(1);
                drive <= 1'b1;
              end
            end
`ifdef BALL_RX_READBACK_EN
            READ: begin
              sh <= {sh[6:0], 1'b0};
              drive <= !bit8 && !sh[6];
            end
`endif
            default: ;
          endcase
`ifdef BALL_RX_READBACK_EN
        if (fall && ((state == ADDR_ACK && rd) || state == READ_ACK)) begin
          bit_cnt <= '0;
          sh <= tx;
          drive <= !tx[7];
          byte_cnt <= byte_cnt + CW'(byte_cnt != NB);
        end
`endif
      end
    end
  end
endmodule
